// File: rtl/systolic_feeder_if.sv
// -----------------------------------------------------------------------------
// systolic_feeder_if
// Bundles the feeder's load stream and its skewed array-side outputs.
//   s_data/s_valid/s_ready : serial load stream, a beat moves when valid&ready
//   hold                   : freezes the feed sequence (only acts while feeding)
//   a_data/a_vld           : N lanes of WIDTH bits, lane i at [i*WIDTH +: WIDTH]
//   busy/done              : feeding in progress / one-cycle end-of-block pulse
// master = producer of the block (testbench or upstream), slave = the feeder.
// -----------------------------------------------------------------------------
interface systolic_feeder_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4
);
  logic [WIDTH-1:0]   s_data;
  logic               s_valid;
  logic               s_ready;
  logic               hold;
  logic [N*WIDTH-1:0] a_data;
  logic [N-1:0]       a_vld;
  logic               busy;
  logic               done;

  modport master (
    output s_data, s_valid, hold,
    input  s_ready, a_data, a_vld, busy, done
  );

  modport slave (
    input  s_data, s_valid, hold,
    output s_ready, a_data, a_vld, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
// Buffers an N x N block (N vectors of N signed elements, row-major stream)
// and replays it diagonally skewed onto the array rows: at step t lane i shows
// X[t-i][i] when 0 <= t-i <= N-1, otherwise 0 with its valid low.
// Ports:
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : systolic_feeder_if.slave (load stream, hold, lanes, busy, done)
// All outputs come straight from flops or from the state register.
// -----------------------------------------------------------------------------
module systolic_feeder #(
  parameter int WIDTH = 16,
  parameter int N     = 4
) (
  input  logic             clk,
  input  logic             rst,
  systolic_feeder_if.slave bus
);

  localparam int DEPTH = N * N;
  localparam int AW    = $clog2(DEPTH);
  localparam int STEPS = 2 * N - 1;
  localparam int SW    = $clog2(STEPS);

  localparam logic [AW-1:0] LAST_BEAT = AW'(DEPTH - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);
  localparam logic [SW-1:0] LAST_ROW  = SW'(N - 1);

  typedef enum logic {LOAD, FEED} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      load_cnt_q, load_cnt_d;
  logic [SW-1:0]      step_q, step_d;
  logic [N*WIDTH-1:0] a_data_q, a_data_d;
  logic [N-1:0]       a_vld_q, a_vld_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   buf_mem [DEPTH];

  logic               beat_fire;
  logic               last_beat;
  logic               feed_adv;
  logic               feed_last;
  logic [SW-1:0]      show_step;
  logic [WIDTH-1:0]   lane_data [N];
  logic [N-1:0]       lane_vld;

  assign beat_fire = (state_q == LOAD) && bus.s_valid;
  assign last_beat = beat_fire && (load_cnt_q == LAST_BEAT);
  assign feed_adv  = (state_q == FEED) && !bus.hold;
  assign feed_last = feed_adv && (step_q == LAST_STEP);

  // Step whose lanes get registered this cycle: step 0 while the final beat
  // arrives (it only needs X[0][0], already stored), else the following step.
  assign show_step = last_beat ? '0 : step_q + SW'(1);

  // Block buffer, no reset: stale contents are never presented because a
  // feed only starts after a full block has been written.
  always_ff @(posedge clk) begin
    if (beat_fire) begin
      buf_mem[load_cnt_q] <= bus.s_data;
    end
  end

  // Per-lane diagonal selection for show_step.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      localparam logic [SW-1:0] LANE = SW'(gi);
      logic [SW-1:0] row;
      logic [AW-1:0] addr;

      assign row          = show_step - LANE;
      assign lane_vld[gi] = (show_step >= LANE) && (row <= LAST_ROW);
      assign addr         = lane_vld[gi] ? (AW'(row) * AW'(N) + AW'(gi)) : '0;
      assign lane_data[gi] = lane_vld[gi] ? buf_mem[addr] : '0;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      step_q     <= '0;
      a_data_q   <= '0;
      a_vld_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      step_q     <= step_d;
      a_data_q   <= a_data_d;
      a_vld_q    <= a_vld_d;
      done_q     <= done_d;
    end
  end

  // Next-state and counters.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    step_d     = step_q;
    case (state_q)
      LOAD: begin
        if (beat_fire) begin
          if (last_beat) begin
            state_d    = FEED;
            load_cnt_d = '0;
            step_d     = '0;
          end else begin
            load_cnt_d = load_cnt_q + AW'(1);
          end
        end
      end
      FEED: begin
        if (feed_adv) begin
          if (feed_last) begin
            state_d = LOAD;
            step_d  = '0;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Registered outputs: load the next step's lanes, keep them on hold,
  // clear them (and pulse done) when the final step retires.
  always_comb begin
    a_data_d = a_data_q;
    a_vld_d  = a_vld_q;
    done_d   = 1'b0;
    if (last_beat || (feed_adv && !feed_last)) begin
      for (int i = 0; i < N; i++) begin
        a_data_d[i*WIDTH +: WIDTH] = lane_data[i];
      end
      a_vld_d = lane_vld;
    end else if (feed_last) begin
      a_data_d = '0;
      a_vld_d  = '0;
      done_d   = 1'b1;
    end else if (state_q == LOAD) begin
      a_data_d = '0;
      a_vld_d  = '0;
    end
  end

  assign bus.s_ready = (state_q == LOAD);
  assign bus.busy    = (state_q == FEED);
  assign bus.a_data  = a_data_q;
  assign bus.a_vld   = a_vld_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
// Directed stimulus for systolic_feeder (N=4, WIDTH=16). The stimulus side
// keeps a copy of each loaded block and pushes the expected per-cycle lane
// picture into a queue; a negedge monitor pops one entry for every cycle the
// DUT shows busy, done or a valid lane.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;

  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int BEATS = N * N;
  localparam int STEPS = 2 * N - 1;

  typedef logic [WIDTH-1:0] blk_t [BEATS];

  typedef struct packed {
    logic [N-1:0]       vld;
    logic [N*WIDTH-1:0] data;
    logic               busy;
    logic               done;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_feeder_if #(.WIDTH(WIDTH), .N(N)) bus ();

  systolic_feeder #(.WIDTH(WIDTH), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rec_t             sb [$];
  int               n_checks = 0;
  int               n_pass   = 0;
  logic [WIDTH-1:0] xm [N][N];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected lane picture for feed step t, taken from the bench's block copy.
  task automatic push_step(input int t);
    rec_t r;
    r = '0;
    r.busy = 1'b1;
    for (int i = 0; i < N; i++) begin
      int row;
      row = t - i;
      if (row >= 0 && row <= N - 1) begin
        r.vld[i] = 1'b1;
        r.data[i*WIDTH +: WIDTH] = xm[row][i];
      end
    end
    sb.push_back(r);
  endtask

  task automatic expect_feed(input int hold_at, input int hold_len, input int stop_at);
    rec_t r;
    for (int t = 0; t < STEPS && t <= stop_at; t++) begin
      push_step(t);
      if (t == hold_at) begin
        for (int h = 0; h < hold_len; h++) push_step(t);
      end
    end
    if (stop_at >= STEPS - 1) begin
      r = '0;
      r.done = 1'b1;
      sb.push_back(r);
    end
  endtask

  // Present nbeats beats; gap idle cycles follow every beat but the last.
  // last_cyc is the cycle in which the final beat transferred.
  task automatic load_block(input blk_t vals, input int nbeats, input int gap, output int last_cyc);
    int busy_seen;
    busy_seen = 0;
    last_cyc  = 0;
    for (int k = 0; k < nbeats; k++) begin
      int waitc;
      waitc = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = vals[k];
      while (!bus.s_ready && waitc < 100) begin
        tick();
        waitc++;
      end
      if (waitc >= 100) begin
        $display("FAIL load_timeout: beat %0d got s_ready=0 for 100 cycles, expected 1", k);
        n_checks++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "load stalled");
      end
      if (bus.busy) busy_seen++;
      last_cyc = cyc;
      xm[k / N][k % N] = vals[k];
      tick();
      if (k != nbeats - 1) begin
        bus.s_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    bus.s_valid = 1'b0;
    check("busy_during_load", 128'(busy_seen), 128'(0));
  endtask

  // Called in cycle L+1; returns in the done cycle.
  task automatic watch_feed(input int last_cyc, input int holds, input string tag);
    int low_cnt;
    bit seen;
    low_cnt = 0;
    seen    = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      if (bus.done) begin
        seen = 1'b1;
        check({tag, "_done_cycle"}, 128'(cyc - last_cyc), 128'(2 * N + holds));
        check({tag, "_ready_low_cycles"}, 128'(low_cnt), 128'(STEPS + holds));
        check({tag, "_ready_in_done"}, 128'(bus.s_ready), 128'(1));
      end else begin
        if (!bus.s_ready) low_cnt++;
        tick();
      end
    end
    if (!seen) check({tag, "_done_timeout"}, 128'(0), 128'(1));
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin : monitor
    rec_t got;
    rec_t exp;
    if (bus.busy || bus.done || (bus.a_vld != '0)) begin
      got.vld  = bus.a_vld;
      got.data = bus.a_data;
      got.busy = bus.busy;
      got.done = bus.done;
      if (sb.size() == 0) begin
        check("unexpected_output", 128'(got), 128'(0));
      end else begin
        exp = sb.pop_front();
        check("feed_step", 128'(got), 128'(exp));
        $display("cycle %0d: vld=%b data=%h busy=%b done=%b", cyc, got.vld, got.data, got.busy, got.done);
      end
    end
  end

  initial begin
    blk_t blk;
    blk_t blk_b;
    int   l_a;
    int   l_b;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.hold    = 1'b0;
    rst         = 1'b1;

    // Reset state.
    tick();
    tick();
    check("reset_state", 128'({bus.a_vld, bus.a_data, bus.s_ready, bus.busy, bus.done}),
          128'({4'b0, 64'b0, 1'b1, 1'b0, 1'b0}));
    rst = 1'b0;
    tick();

    // Basic skew: 1.0 .. 16.0 in Q6.10.
    for (int k = 0; k < BEATS; k++) blk[k] = WIDTH'((k + 1) * 16'h0400);
    load_block(blk, BEATS, 0, l_a);
    expect_feed(-1, 0, 99);
    check("basic_t0_vld", 128'(bus.a_vld), 128'(4'b0001));
    check("basic_t0_lane0", 128'(bus.a_data[15:0]), 128'(16'h0400));
    repeat (3) tick();
    check("basic_t3_vld", 128'(bus.a_vld), 128'(4'b1111));
    check("basic_t3_data", 128'(bus.a_data), 128'(64'h1000_1C00_2800_3400));
    repeat (3) tick();
    check("basic_t6_vld", 128'(bus.a_vld), 128'(4'b1000));
    check("basic_t6_lane3", 128'(bus.a_data[63:48]), 128'(16'h4000));
    tick();
    check("basic_done", 128'(bus.done), 128'(1));
    tick();

    // Signed passthrough.
    for (int k = 0; k < BEATS; k++) blk[k] = (k % 2 == 0) ? 16'h8000 : 16'hFFFF;
    load_block(blk, BEATS, 0, l_a);
    expect_feed(-1, 0, 99);
    watch_feed(l_a, 0, "signed");
    tick();

    // Hold for 3 cycles at t=2.
    for (int k = 0; k < BEATS; k++) blk[k] = WIDTH'(16'h0A00 + k * 16'h0101);
    load_block(blk, BEATS, 0, l_a);
    expect_feed(2, 3, 99);
    fork
      watch_feed(l_a, 3, "hold");
      begin
        repeat (2) tick();
        bus.hold = 1'b1;
        repeat (3) tick();
        bus.hold = 1'b0;
      end
    join
    tick();

    // 1-0-0 gaps with hold high during LOAD, then block B back-to-back with
    // its beat 0 waiting through A's feed.
    for (int k = 0; k < BEATS; k++) blk[k]   = WIDTH'(16'hC000 + k * 16'h0011);
    for (int k = 0; k < BEATS; k++) blk_b[k] = WIDTH'(16'h3000 - k * 16'h0123);
    bus.hold = 1'b1;
    load_block(blk, BEATS, 2, l_a);
    bus.hold = 1'b0;
    expect_feed(-1, 0, 99);
    fork
      watch_feed(l_a, 0, "gaps");
      load_block(blk_b, BEATS, 0, l_b);
    join
    expect_feed(-1, 0, 99);
    check("b2b_period", 128'(l_b - l_a), 128'(BEATS + STEPS));
    watch_feed(l_b, 0, "b2b");
    tick();

    // Reset at t=4, then a fresh block.
    for (int k = 0; k < BEATS; k++) blk[k] = WIDTH'(16'h5500 + k);
    load_block(blk, BEATS, 0, l_a);
    expect_feed(-1, 0, 4);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_feed_outputs", 128'({bus.a_vld, bus.a_data, bus.s_ready, bus.busy, bus.done}),
          128'({4'b0, 64'b0, 1'b1, 1'b0, 1'b0}));
    for (int k = 0; k < BEATS; k++) blk[k] = WIDTH'(16'h9900 + k * 16'h0202);
    load_block(blk, BEATS, 0, l_a);
    expect_feed(-1, 0, 99);
    watch_feed(l_a, 0, "after_rst_feed");
    tick();

    // Reset after 9 beats; next 16 beats form the block.
    for (int k = 0; k < BEATS; k++) blk[k] = 16'hDEAD;
    load_block(blk, 9, 0, l_a);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < BEATS; k++) blk[k] = WIDTH'(16'h0100 * k + 16'h0007);
    load_block(blk, BEATS, 0, l_a);
    expect_feed(-1, 0, 99);
    watch_feed(l_a, 0, "after_rst_load");
    tick();

    repeat (3) tick();
    check("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Input skew stage for the N×N systolic matrix-vector array built from the `pe` processing element. It accepts a block of N input vectors, each N elements long, as a serial valid/ready stream and buffers the whole block. It then drives the array's row inputs diagonally skewed, so lane i runs i cycles behind lane 0. Data is signed fixed-point and is passed through unmodified; the Q format (WIDTH=16, 10 fractional bits) is only interpreted downstream.

## Interface
- `WIDTH`, 16: element width in bits (signed).
- `N`, 4: array dimension; vectors per block and elements per vector. Must be ≥2.
- `clk` input, 1: the single clock. All logic is rising-edge.
- `rst` input, 1: reset, synchronous and active-high.
- `s_data` input, WIDTH: input element.
- `s_valid` input, 1: `s_data` is valid.
- `s_ready` output, 1: the feeder can accept a beat. A beat transfers when `s_valid` and `s_ready` are both high.
- `hold` input, 1: freezes the feed sequence while high. Ignored outside FEED.
- `a_data` output, N*WIDTH: lane i occupies bits [i*WIDTH +: WIDTH] and drives array row i.
- `a_vld` output, N: per-lane valid.
- `busy` output, 1: high while in FEED.
- `done` output, 1: one-cycle pulse when a block has been fully fed.

## Operation
- States:
  - LOAD (the reset state): `s_ready`=1. Beat k (0..N*N-1) is written to X[k/N][k%N]; row index = vector index, so the input is row-major.
  - FEED: the step counter t runs 0..2N-2. `s_ready`=0 and `busy`=1.
- Transitions:
  - LOAD→FEED on the transfer of beat N*N-1.
  - FEED→LOAD after step t=2N-2 has been presented for one non-held cycle.
- Lane rule for FEED step t:
  - Lane i is valid when 0 ≤ t-i ≤ N-1. Then `a_vld[i]`=1 and lane i = X[t-i][i].
  - Otherwise `a_vld[i]`=0 and lane i = 0.
- Data is copied bit-exact: no arithmetic, no width change, no saturation.
- `hold`=1 in FEED: t, `a_data` and `a_vld` are frozen and no `done` is issued.
- `hold` has no effect in LOAD. Gaps in `s_valid` simply stall the load counter.
- Outputs are zero outside FEED: in LOAD, `a_data`=0 and `a_vld`=0.
- `done` asserts for exactly one cycle: the first cycle back in LOAD. During that same cycle `s_ready`=1, so beat 0 of the next block may transfer.
- `rst` (including mid-LOAD or mid-FEED):
  - Next cycle: state LOAD, both counters 0, `s_ready`=1, `a_data`=0, `a_vld`=0, `busy`=0, `done`=0.
  - A partially loaded block is discarded. Buffer contents are not cleared and are not observable.

## Timing
- All outputs are registered.
- Let L be the cycle in which the last beat (N*N-1) transfers, with no hold:
  - Cycle L+1: step t=0 is on the outputs, and `busy`=1.
  - Cycle L+1+t: step t is on the outputs. The last step is at L+2N-1.
  - Cycle L+2N: `a_vld`=0, `a_data`=0, `busy`=0, `done`=1, `s_ready`=1.
- `s_ready` is low for exactly 2N-1 cycles per block, plus one cycle for each held cycle.
- Each held cycle extends FEED by one cycle. It does not skip or duplicate any step.
- Minimum block period is N*N + 2N-1 cycles with continuous `s_valid`. For N=4 that is 23.
- Hold asserted in cycle c affects the register update at the end of c, so outputs stay unchanged in c+1.

## Test plan
- **Basic skew** (N=4). Stream X[r][c] = (4r+c+1)·0x0400 (1.0 to 16.0 in Q6.10) with `s_valid` held high.
  - At L+1: only lane 0 is valid, = 0x0400.
  - At L+4 (t=3): `a_vld`=4'b1111; lanes 0..3 = 0x3400, 0x2800, 0x1C00, 0x1000.
  - At L+7 (t=6): only lane 3 is valid, = 0x4000.
  - At L+8: `done`=1.
- **Signed passthrough**. Load all elements = 0x8000 and 0xFFFF alternately.
  - Every valid lane value matches bit-exactly.
  - Invalid lanes are 0x0000.
- **Back-pressure and gaps**. Drive `s_valid` with a 1-0-0 pattern during LOAD; keep `s_valid` high through FEED.
  - Exactly 16 beats are accepted.
  - `s_ready`=0 for the 7 FEED cycles.
  - No beat transfers while `s_ready` is low.
- **Hold**. Assert `hold` for 3 cycles at t=2.
  - The t=2 outputs persist for 4 cycles total.
  - The sequence then resumes at t=3.
  - `done` arrives 3 cycles later than in the unheld case (at L+11).
- **Reset mid-operation**.
  - `rst` at t=4: the next cycle has all outputs 0 and `s_ready`=1. A fresh 16-beat block then feeds correctly.
  - `rst` after 9 beats in LOAD: the next 16 beats form a new block.
- **Back-to-back blocks**. Load block A, then present block B's beat 0 in the `done` cycle.
  - The beat is accepted.
  - B is fed with period 23 cycles and its contents are uncorrupted by A.
